// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_AF_THRESH  = 12;

    // FIFO status word, also consumed by the MMIO register block.
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overrun;
    } fifo_status_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus between the RX byte stream / MMIO reader and the receive FIFO.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready stream on the write side, rd_en strobe on the read side.
// master: RX engine + MMIO side (drives in_*, rd_en, flush, ovr_clr)
// slave : FIFO side (drives in_ready, rd_*, count and flags)
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     rd_en;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_valid;
    logic                     flush;
    logic                     ovr_clr;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic                     overrun;

    modport master (
        output in_valid, in_data, rd_en, flush, ovr_clr,
        input  in_ready, rd_data, rd_valid, count, empty, full, almost_full, overrun
    );

    modport slave (
        input  in_valid, in_data, rd_en, flush, ovr_clr,
        output in_ready, rd_data, rd_valid, count, empty, full, almost_full, overrun
    );
endinterface

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the RX FIFO, DEPTH x DATA_W, LUTRAM style.
// Latency: write lands on the clock edge, read is combinational from raddr.
// Backpressure: none; caller gates we.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module uart_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on storage: validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer after the UART RX engine: circular FIFO, FWFT read side, level/flags, sticky overrun.
// Latency: byte pushed in cycle N is visible on rd_data/rd_valid in cycle N+1.
// Backpressure: in_ready = !full (registered) and low during flush; a stall while full sets overrun.
// Ports: clk, rst (async active-high), bus (uart_rx_fifo_if.slave: stream in, read strobe, flush, ovr_clr, count, flags).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_FIFO_DEPTH,
    parameter int DATA_W    = UART_DATA_W,
    parameter int AF_THRESH = UART_AF_THRESH
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovr;
    logic              push;
    logic              pop;
    logic              ovr_set;
    logic [DATA_W-1:0] ram_rdata;
    fifo_status_t      st;

    always_comb begin
        st.empty       = (cnt == '0);
        st.full        = (cnt == CW'(DEPTH));
        st.almost_full = (cnt >= CW'(AF_THRESH));
        st.overrun     = ovr;
    end

    // in_ready comes only from the registered count, so a same-cycle pop
    // cannot open a slot for a push when full.
    assign bus.in_ready = !st.full && !bus.flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.rd_en && !st.empty && !bus.flush;

    // Only a stall caused by a full FIFO counts as overrun; the flush-cycle
    // refusal is a deliberate discard, not an upstream stall.
    assign ovr_set = bus.in_valid && st.full && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (ovr_set) begin
            ovr <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr <= 1'b0;
        end
    end

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Stale RAM contents are masked so an empty FIFO always reads zero.
    assign bus.rd_data     = st.empty ? '0 : ram_rdata;
    assign bus.rd_valid    = !st.empty;
    assign bus.count       = cnt;
    assign bus.empty       = st.empty;
    assign bus.full        = st.full;
    assign bus.almost_full = st.almost_full;
    assign bus.overrun     = st.overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random phase, against a queue model.
// Latency: n/a.
// Backpressure: model refuses pushes when it holds DEPTH bytes or during flush.
module tb_uart_rx_fifo;
    localparam int DEPTH     = 16;
    localparam int DATA_W    = 8;
    localparam int AF_THRESH = 12;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [7:0] q[$];
    logic       ovr_m;

    uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"},    32'(bus.count),       32'(sz));
        chk({tag, ".empty"},    32'(bus.empty),       32'(sz == 0));
        chk({tag, ".full"},     32'(bus.full),        32'(sz == DEPTH));
        chk({tag, ".af"},       32'(bus.almost_full), 32'(sz >= AF_THRESH));
        chk({tag, ".overrun"},  32'(bus.overrun),     32'(ovr_m));
        chk({tag, ".in_ready"}, 32'(bus.in_ready),    32'(sz < DEPTH));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid),    32'(sz != 0));
        chk({tag, ".rd_data"},  32'(bus.rd_data),     (sz != 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_en    = 1'b0;
        bus.flush    = 1'b0;
        bus.ovr_clr  = 1'b0;
    endtask

    // One clock cycle: drive, advance the model by the FIFO rules, check.
    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic c, input string tag);
        int         sz;
        logic [7:0] h;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.rd_en    = r;
        bus.flush    = f;
        bus.ovr_clr  = c;
        sz = q.size();
        #1;
        chk({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'(!f && sz < DEPTH));
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (r && sz > 0) h = q.pop_front();
            if (v && sz < DEPTH) q.push_back(d);
        end
        if (v && sz == DEPTH && !f) ovr_m = 1'b1;
        else if (c) ovr_m = 1'b0;
        #1;
        idle();
        #1;
        check_all(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ovr_m = 1'b0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: three bytes, first visible one cycle after push
        step(1, 8'h41, 0, 0, 0, "t1_push");
        chk("t1_head_after_first", 32'(bus.rd_data), 32'h41);
        step(1, 8'h42, 0, 0, 0, "t1_push");
        step(1, 8'h43, 0, 0, 0, "t1_push");
        chk("t1_count3", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "t1_drain");

        // 2: fill, flags, overrun on stall, drain in order
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0, "t2_fill");
            chk("t2_af", 32'(bus.almost_full), 32'(i + 1 >= 12));
        end
        chk("t2_full", 32'(bus.full), 32'd1);
        chk("t2_in_ready", 32'(bus.in_ready), 32'd0);
        step(1, 8'hAA, 0, 0, 0, "t2_stall");
        chk("t2_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(bus.rd_data), 32'(i));
            step(0, 0, 1, 0, 0, "t2_drain");
        end
        chk("t2_aa_not_stored", 32'(bus.empty), 32'd1);
        step(0, 0, 0, 0, 1, "t2_ovr_clr");

        // 3: steady push+pop at level 5 across several pointer wraps
        for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0, 0, "t3_prime");
        for (int k = 0; k < 3 * DEPTH; k++) begin
            chk("t3_head", 32'(bus.rd_data), 32'(8'(8'h80 + k)));
            step(1, 8'(8'h80 + k + 5), 1, 0, 0, "t3_stream");
            chk("t3_count5", 32'(bus.count), 32'd5);
        end
        for (int k = 0; k < 5; k++) begin
            chk("t3_tail", 32'(bus.rd_data), 32'(8'(8'h80 + 3 * DEPTH + k)));
            step(0, 0, 1, 0, 0, "t3_drain");
        end

        // 4: pop on empty, then push+pop from empty
        step(0, 0, 1, 0, 0, "t4_pop_empty");
        chk("t4_count0", 32'(bus.count), 32'd0);
        chk("t4_rd0", 32'(bus.rd_data), 32'd0);
        step(1, 8'h77, 1, 0, 0, "t4_pushpop");
        chk("t4_count1", 32'(bus.count), 32'd1);
        chk("t4_head", 32'(bus.rd_data), 32'h77);
        step(0, 0, 1, 0, 0, "t4_drain");

        // 5: flush at count 7 with overrun already set
        for (int i = 0; i < 16; i++) step(1, 8'(8'h30 + i), 0, 0, 0, "t5_fill");
        step(1, 8'hEE, 0, 0, 0, "t5_stall");
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, "t5_pop");
        chk("t5_count7", 32'(bus.count), 32'd7);
        step(1, 8'h55, 1, 1, 0, "t5_flush");
        chk("t5_count0", 32'(bus.count), 32'd0);
        chk("t5_empty", 32'(bus.empty), 32'd1);
        chk("t5_ovr_kept", 32'(bus.overrun), 32'd1);
        step(1, 8'h66, 0, 0, 0, "t5_after");
        chk("t5_head66", 32'(bus.rd_data), 32'h66);
        step(0, 0, 1, 0, 0, "t5_drain");

        // 6: async reset at count 9, then set+clear race on overrun
        for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, "t6_fill");
        chk("t6_count9", 32'(bus.count), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        ovr_m = 1'b0;
        check_all("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(1, 8'h99, 0, 0, 0, "t6_post_rst");
        chk("t6_head99", 32'(bus.rd_data), 32'h99);
        step(0, 0, 1, 0, 0, "t6_drain");
        for (int i = 0; i < 16; i++) step(1, 8'(i * 3), 0, 0, 0, "t6_fill2");
        step(1, 8'h11, 0, 0, 1, "t6_set_clr");
        chk("t6_set_wins", 32'(bus.overrun), 32'd1);
        step(0, 0, 0, 0, 1, "t6_clr");
        chk("t6_cleared", 32'(bus.overrun), 32'd0);

        // Random phase: fill-biased then drain-biased traffic, rare flush/clear
        for (int n = 0; n < 800; n++) begin
            logic v, r, f, c;
            if (n < 400) begin
                v = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                v = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(v, 8'($urandom_range(0, 255)), r, f, c, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
